// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_if.sv
// ad_ip_jesd204_tpl_adc_pnmon_if: sample/status bundle between a converter channel and its PN monitor.
// master drives data and pn_seq_sel; slave (the monitor) returns pn_err, pn_oos and pn_err_count.
interface ad_ip_jesd204_tpl_adc_pnmon_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            pn_seq_sel;
    logic                  pn_err;
    logic                  pn_oos;
    logic [31:0]           pn_err_count;
    modport master (output data, pn_seq_sel, input pn_err, pn_oos, pn_err_count);
    modport slave (input data, pn_seq_sel, output pn_err, pn_oos, pn_err_count);
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// ad_ip_jesd204_tpl_adc_pnmon: PN7/PN15 monitor for one converter channel, OOS/SYNC lock tracking.
// Ports: link_clk (only clock), adc_rst (sync active-high reset),
//        pn.slave: data, pn_seq_sel in; pn_err, pn_oos, pn_err_count out.
// Optional saturating error counter enabled by macro TPL_PNMON_ERR_CNT_EN (pn_err_count=0 otherwise).
module ad_ip_jesd204_tpl_adc_pnmon #(
    parameter int DATA_WIDTH    = 16,
    parameter int OOS_THRESHOLD = 16
) (
    input  logic                           link_clk,
    input  logic                           adc_rst,
    ad_ip_jesd204_tpl_adc_pnmon_if.slave   pn
);
    typedef enum logic {OOS, SYNC} state_t;
    state_t                state;
    logic [7:0]            run_cnt;
    logic [DATA_WIDTH-1:0] data_q, exp_q, ref_w, exp_w;
    logic [3:0]            sel_q;
    logic                  err_q, en, chg, match, hit, err_d;

    // Extends the reference word by DATA_WIDTH LFSR bits; higher bit positions are older.
    function automatic logic [DATA_WIDTH-1:0] pn_next(input logic [DATA_WIDTH-1:0] r, input logic pn15);
        logic [2*DATA_WIDTH-1:0] s;
        s = {r, {DATA_WIDTH{1'b0}}};
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            s[i] = pn15 ? s[i+15] ^ s[i+14] : s[i+7] ^ s[i+6];
        return s[DATA_WIDTH-1:0];
    endfunction

    assign en    = sel_q == 4'h4 || sel_q == 4'h5;
    assign chg   = pn.pn_seq_sel != sel_q;
    // Out of sync we seed from the received stream; in sync we free-run on our own prediction.
    assign ref_w = state == OOS ? data_q : exp_q;
    assign exp_w = pn_next(ref_w, sel_q == 4'h5);
    assign match = pn.data == exp_w && pn.data != '0;
    assign hit   = run_cnt >= 8'(OOS_THRESHOLD - 1);
    assign err_d = en && !chg && state == SYNC && !match;

    always_ff @(posedge link_clk) begin
        if (adc_rst) begin
            state   <= OOS;
            run_cnt <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q <= pn.data;
            exp_q  <= exp_w;
            sel_q  <= pn.pn_seq_sel;
            err_q  <= err_d;
            if (chg || !en) begin
                state   <= OOS;
                run_cnt <= '0;
            end else begin
                // The run counts toward leaving the current state and restarts on the opposite outcome.
                run_cnt <= (state == OOS) != match || hit ? '0 : run_cnt + 8'd1;
                if ((state == OOS) == match && hit)
                    state <= state == OOS ? SYNC : OOS;
            end
        end
    end

    assign pn.pn_err = err_q;
    assign pn.pn_oos = state == OOS;

`ifdef TPL_PNMON_ERR_CNT_EN
    logic [31:0] err_cnt;
    always_ff @(posedge link_clk) begin
        if (adc_rst || chg)
            err_cnt <= '0;
        else if (err_d && err_cnt != '1)
            err_cnt <= err_cnt + 32'd1;
    end
    assign pn.pn_err_count = err_cnt;
`else
    assign pn.pn_err_count = 32'h0;
`endif
endmodule
